// File: rtl/perf_counter_ctrl.sv
// Performance-counter bank: nine saturating 32-bit event counters, CTRL/OVF
// registers, and a two-state request/response handshake toward the core.

module perf_cnt_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        wr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lane_mask_i,
  input  logic        inc_i,
  output logic [31:0] cnt_o,
  output logic        sat_o
);
  logic [31:0] cnt_q, cnt_d;

  // A dropped event (clear or write wins) must not raise the saturation flag.
  assign sat_o = inc_i && !clr_i && !wr_i && (cnt_q == 32'hFFFF_FFFF);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (wr_i)
      cnt_d = (cnt_q & ~lane_mask_i) | (wdata_i & lane_mask_i);
    else if (inc_i && (cnt_q != 32'hFFFF_FFFF))
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

module perf_counter_ctrl #(
  parameter int NUM_CNT = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ev_branch,
  input  logic        ev_mispredict,
  input  logic        ev_icache_hit,
  input  logic        ev_icache_miss,
  input  logic        ev_dcache_hit,
  input  logic        ev_dcache_miss,
  input  logic        ev_l2_hit,
  input  logic        ev_l2_miss,
  input  logic        ev_stall,
  input  logic        pc_read,
  input  logic        pc_write,
  input  logic [31:0] pc_address,
  input  logic [31:0] pc_wdata,
  input  logic [3:0]  pc_byte_enable,
  output logic [31:0] pc_rdata,
  output logic        pc_resp
);
  typedef enum logic {S_IDLE, S_RESP} state_e;

  state_e                     state_q, state_d;
  logic [31:0]                rdata_q, rdata_d;
  logic                       en_q, en_d;
  logic [NUM_CNT-1:0]         ovf_q, ovf_d;
  logic [NUM_CNT-1:0]         ev_vec, sat_set;
  logic [NUM_CNT-1:0][31:0]   cnt;
  logic [31:0]                lane_mask, rd_val;
  logic [29:0]                word;
  logic                       accept, wr_acc, sel_ctrl, sel_ovf, clear_all;
  logic                       unused_addr;

  assign unused_addr = ^pc_address[1:0];
  assign word        = pc_address[31:2];
  assign accept      = (state_q == S_IDLE) && (pc_read || pc_write);
  assign wr_acc      = accept && pc_write;
  assign sel_ctrl    = (word == 30'd9);
  assign sel_ovf     = (word == 30'd10);
  assign lane_mask   = {{8{pc_byte_enable[3]}}, {8{pc_byte_enable[2]}},
                        {8{pc_byte_enable[1]}}, {8{pc_byte_enable[0]}}};

  // clear_all lives in byte 0 and always reads back 0, so the merge reduces
  // to "lane 0 enabled and bit 1 written high".
  assign clear_all = wr_acc && sel_ctrl && pc_byte_enable[0] && pc_wdata[1];

  assign ev_vec = {ev_stall, ev_l2_miss, ev_l2_hit, ev_dcache_miss, ev_dcache_hit,
                   ev_icache_miss, ev_icache_hit, ev_mispredict, ev_branch};

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_lane
    perf_cnt_lane u_lane (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (clear_all),
      .wr_i        (wr_acc && (word == 30'(g))),
      .wdata_i     (pc_wdata),
      .lane_mask_i (lane_mask),
      .inc_i       (en_q && ev_vec[g]),
      .cnt_o       (cnt[g]),
      .sat_o       (sat_set[g])
    );
  end

  always_comb begin
    en_d = en_q;
    if (wr_acc && sel_ctrl && pc_byte_enable[0]) en_d = pc_wdata[0];
  end

  // Saturation set is applied after the W1C so a same-cycle set survives.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_acc && sel_ovf)
      ovf_d = ovf_q & ~(pc_wdata[NUM_CNT-1:0] & lane_mask[NUM_CNT-1:0]);
    ovf_d = ovf_d | sat_set;
    if (clear_all) ovf_d = '0;
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CNT; i++)
      if (word == 30'(i)) rd_val = cnt[i];
    if (sel_ctrl) rd_val = {31'd0, en_q};
    if (sel_ovf)  rd_val = {{(32-NUM_CNT){1'b0}}, ovf_q};
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_RESP;
        rdata_d = rd_val;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      en_q    <= 1'b1;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pc_resp  = (state_q == S_RESP);
  assign pc_rdata = rdata_q;
endmodule
